// File: rtl/coolgirl_scanline_irq_if.sv
// Bus bundle for the CoolGirl scanline IRQ unit: decoded CPU register writes,
// raw PPU A12 and the IRQ/debug outputs.
interface coolgirl_scanline_irq_if;
  logic        write_strobe;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq;
  logic        irq_pending;
  logic [7:0]  counter;

  modport master (
    output write_strobe,
    output cpu_addr_in,
    output cpu_data_in,
    output ppu_a12,
    input  irq,
    input  irq_pending,
    input  counter
  );

  modport slave (
    input  write_strobe,
    input  cpu_addr_in,
    input  cpu_data_in,
    input  ppu_a12,
    output irq,
    output irq_pending,
    output counter
  );
endinterface

// File: rtl/coolgirl_scanline_irq.sv
// MMC3-style scanline IRQ: counts filtered PPU A12 rising edges on CPU m2 and
// drives the active-low cartridge IRQ from the $C000-$FFFF register set.
module coolgirl_scanline_irq #(
  parameter int A12_LOW_MIN = 3,
  parameter bit REV_A       = 1'b0
) (
  input  logic                          m2,
  input  logic                          reset_n,
  coolgirl_scanline_irq_if.slave        bus
);

  localparam int LOW_W = (A12_LOW_MIN < 1) ? 1 : $clog2(A12_LOW_MIN + 1);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_LOW_MIN);

  logic             a12_meta_q;
  logic             a12_s_q;
  logic             a12_prev_q;
  logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]       latch_q, latch_d;
  logic [7:0]       counter_q, counter_d;
  logic             reload_q, reload_d;
  logic             enabled_q, enabled_d;
  logic             pending_q, pending_d;
  logic             irq_q;
  logic             a12_event;
  logic [7:0]       pre_counter;
  logic             pre_reload;
  logic             irq_set;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.cpu_addr_in[12:1];

  // A rise only counts after A12 has been quiet long enough to filter PPU fetch jitter.
  assign a12_event = a12_s_q & ~a12_prev_q & (low_cnt_q == LOW_MAX);

  always_comb begin
    low_cnt_d   = low_cnt_q;
    latch_d     = latch_q;
    counter_d   = counter_q;
    reload_d    = reload_q;
    enabled_d   = enabled_q;
    pending_d   = pending_q;
    pre_counter = 8'd0;
    pre_reload  = 1'b0;
    irq_set     = 1'b0;

    if (a12_s_q) begin
      low_cnt_d = {LOW_W{1'b0}};
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + {{(LOW_W-1){1'b0}}, 1'b1};
    end else begin
      low_cnt_d = low_cnt_q;
    end

    if (bus.write_strobe && bus.cpu_addr_in[14]) begin
      case ({bus.cpu_addr_in[13], bus.cpu_addr_in[0]})
        2'b00: latch_d = bus.cpu_data_in;
        2'b01: begin
          counter_d = 8'd0;
          reload_d  = 1'b1;
        end
        2'b10: begin
          enabled_d = 1'b0;
          pending_d = 1'b0;
        end
        2'b11: enabled_d = 1'b1;
        default: latch_d = latch_q;
      endcase
    end else begin
      latch_d = latch_q;
    end

    // The scanline event sees the state as already modified by a same-cycle write.
    if (a12_event) begin
      pre_counter = counter_d;
      pre_reload  = reload_d;
      if ((counter_d == 8'd0) || reload_d) begin
        counter_d = latch_d;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_d - 8'd1;
      end
      if (REV_A) begin
        irq_set = (counter_d == 8'd0) && enabled_d &&
                  ((pre_counter != 8'd0) || (pre_reload && (latch_d != 8'd0)));
      end else begin
        irq_set = (counter_d == 8'd0) && enabled_d;
      end
      if (irq_set) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end else begin
      counter_d = counter_d;
    end
  end

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      a12_meta_q <= 1'b0;
      a12_s_q    <= 1'b0;
      a12_prev_q <= 1'b0;
      low_cnt_q  <= {LOW_W{1'b0}};
      latch_q    <= 8'd0;
      counter_q  <= 8'd0;
      reload_q   <= 1'b0;
      enabled_q  <= 1'b0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b1;
    end else begin
      a12_meta_q <= bus.ppu_a12;
      a12_s_q    <= a12_meta_q;
      a12_prev_q <= a12_s_q;
      low_cnt_q  <= low_cnt_d;
      latch_q    <= latch_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      enabled_q  <= enabled_d;
      pending_q  <= pending_d;
      irq_q      <= ~pending_d;
    end
  end

  assign bus.irq         = irq_q;
  assign bus.irq_pending = pending_q;
  assign bus.counter     = counter_q;

endmodule

// File: tb/tb_coolgirl_scanline_irq.sv
// Bench for coolgirl_scanline_irq: both revisions driven in lock-step and
// compared every m2 cycle against a pin-history reference model.
module tb_coolgirl_scanline_irq;

  localparam int A12_LOW_MIN = 3;

  logic m2 = 1'b0;
  logic reset_n;

  coolgirl_scanline_irq_if bus_new ();
  coolgirl_scanline_irq_if bus_old ();

  coolgirl_scanline_irq #(.A12_LOW_MIN(A12_LOW_MIN), .REV_A(1'b0)) u_new (
    .m2(m2), .reset_n(reset_n), .bus(bus_new)
  );
  coolgirl_scanline_irq #(.A12_LOW_MIN(A12_LOW_MIN), .REV_A(1'b1)) u_old (
    .m2(m2), .reset_n(reset_n), .bus(bus_old)
  );

  always #5 m2 = ~m2;

  int checks = 0;
  int errors = 0;
  string cur_tag = "reset";

  // Reference state: index 0 = new behaviour, 1 = old (rev A) behaviour.
  logic [7:0] m_latch [2];
  logic [7:0] m_cnt   [2];
  bit         m_rl    [2];
  bit         m_en    [2];
  bit         m_pend  [2];
  bit         hist    [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_latch[r] = 8'd0; m_cnt[r] = 8'd0; m_rl[r] = 1'b0; m_en[r] = 1'b0; m_pend[r] = 1'b0;
    end
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  // hist holds the A12 pin value seen at each edge; an edge counts when the
  // pin was high two edges ago after at least A12_LOW_MIN known low samples.
  task automatic model_edge(input bit ws, input logic [14:0] addr, input logic [7:0] data, input bit a12);
    bit ev;
    int l;
    logic [7:0] old_cnt;
    bit old_rl;
    bit set;
    hist.push_back(a12);
    l = hist.size();
    ev = 1'b0;
    if ((l - 3 - A12_LOW_MIN >= 0) && hist[l-3]) begin
      ev = 1'b1;
      for (int i = 1; i <= A12_LOW_MIN; i++) if (hist[l-3-i]) ev = 1'b0;
    end
    while (hist.size() > A12_LOW_MIN + 3) void'(hist.pop_front());
    for (int r = 0; r < 2; r++) begin
      if (ws && addr[14]) begin
        if (!addr[13] && !addr[0]) m_latch[r] = data;
        if (!addr[13] &&  addr[0]) begin m_cnt[r] = 8'd0; m_rl[r] = 1'b1; end
        if ( addr[13] && !addr[0]) begin m_en[r] = 1'b0; m_pend[r] = 1'b0; end
        if ( addr[13] &&  addr[0]) m_en[r] = 1'b1;
      end
      if (ev) begin
        old_cnt = m_cnt[r];
        old_rl  = m_rl[r];
        if (m_cnt[r] == 8'd0 || m_rl[r]) begin
          m_cnt[r] = m_latch[r];
          m_rl[r]  = 1'b0;
        end else begin
          m_cnt[r] = m_cnt[r] - 8'd1;
        end
        if (r == 0) set = (m_cnt[r] == 8'd0) && m_en[r];
        else set = (m_cnt[r] == 8'd0) && m_en[r] && ((old_cnt != 8'd0) || (old_rl && m_latch[r] != 8'd0));
        if (set) m_pend[r] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val({cur_tag, "/cnt_new"},  32'(bus_new.counter),     32'(m_cnt[0]));
    check_val({cur_tag, "/irq_new"},  32'(bus_new.irq),         32'(!m_pend[0]));
    check_val({cur_tag, "/pend_new"}, 32'(bus_new.irq_pending), 32'(m_pend[0]));
    check_val({cur_tag, "/cnt_old"},  32'(bus_old.counter),     32'(m_cnt[1]));
    check_val({cur_tag, "/irq_old"},  32'(bus_old.irq),         32'(!m_pend[1]));
    check_val({cur_tag, "/pend_old"}, 32'(bus_old.irq_pending), 32'(m_pend[1]));
  endtask

  task automatic drive(input bit ws, input logic [14:0] addr, input logic [7:0] data, input bit a12);
    bus_new.write_strobe = ws; bus_new.cpu_addr_in = addr; bus_new.cpu_data_in = data; bus_new.ppu_a12 = a12;
    bus_old.write_strobe = ws; bus_old.cpu_addr_in = addr; bus_old.cpu_data_in = data; bus_old.ppu_a12 = a12;
  endtask

  // One m2 cycle: drive after a negedge, model at the posedge, check at the next negedge.
  task automatic step(input bit ws, input logic [14:0] addr, input logic [7:0] data, input bit a12);
    drive(ws, addr, data, a12);
    @(posedge m2);
    model_edge(ws, addr, data, a12);
    @(negedge m2);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 15'h0000, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [14:0] addr, input logic [7:0] data);
    step(1'b1, addr, data, 1'b0);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b0, 15'h0000, 8'h00, 1'b1);
    for (int i = 0; i < lo; i++) step(1'b0, 15'h0000, 8'h00, 1'b0);
  endtask

  // Register write landing on the very edge where the A12 rise is processed.
  task automatic pulse_write(input logic [14:0] addr, input logic [7:0] data);
    step(1'b0, 15'h0000, 8'h00, 1'b1);
    step(1'b0, 15'h0000, 8'h00, 1'b1);
    step(1'b1, addr, data, 1'b0);
    idle(9);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val({cur_tag, "/rst_irq_new"}, 32'(bus_new.irq), 32'd1);
    check_val({cur_tag, "/rst_cnt_new"}, 32'(bus_new.counter), 32'd0);
    check_val({cur_tag, "/rst_irq_old"}, 32'(bus_old.irq), 32'd1);
    check_val({cur_tag, "/rst_cnt_old"}, 32'(bus_old.counter), 32'd0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [14:0] addr;
    bit a12;
    int run;
    reset_n = 1'b0;
    drive(1'b0, 15'h0000, 8'h00, 1'b0);
    model_reset();
    @(negedge m2);
    check_outputs();
    check_val("reset/irq", 32'(bus_new.irq), 32'd1);
    reset_n = 1'b1;

    cur_tag = "s1_count";
    wr(15'h4000, 8'h03); wr(15'h4001, 8'h00); wr(15'h6001, 8'h00);
    pulse(2, 10); check_val("s1/cnt3", 32'(bus_new.counter), 32'd3);
    pulse(2, 10); check_val("s1/cnt2", 32'(bus_new.counter), 32'd2);
    pulse(2, 10); check_val("s1/cnt1", 32'(bus_new.counter), 32'd1);
    step(1'b0, 15'h0000, 8'h00, 1'b1);
    step(1'b0, 15'h0000, 8'h00, 1'b1);
    check_val("s1/irq_not_yet", 32'(bus_new.irq), 32'd1);
    step(1'b0, 15'h0000, 8'h00, 1'b0);
    check_val("s1/irq_fall", 32'(bus_new.irq), 32'd0);
    check_val("s1/cnt0", 32'(bus_new.counter), 32'd0);
    idle(8);
    check_val("s1/irq_held", 32'(bus_old.irq), 32'd0);
    wr(15'h6000, 8'h00);
    check_val("s1/ack", 32'(bus_new.irq), 32'd1);

    cur_tag = "s2_filter";
    wr(15'h4001, 8'h00); idle(4);
    for (int i = 0; i < 4; i++) pulse(2, 2);
    idle(6);
    check_val("s2/one_count", 32'(bus_new.counter), 32'd3);

    cur_tag = "s3_reload_edge";
    wr(15'h6001, 8'h00); wr(15'h4000, 8'h05);
    pulse(2, 10); check_val("s3/cnt2", 32'(bus_new.counter), 32'd2);
    pulse_write(15'h4001, 8'h00);
    check_val("s3/cnt5", 32'(bus_new.counter), 32'd5);
    check_val("s3/no_irq", 32'(bus_new.irq), 32'd1);

    cur_tag = "s4_en_edge";
    wr(15'h4000, 8'h01); wr(15'h4001, 8'h00); wr(15'h6001, 8'h00);
    pulse(2, 10); check_val("s4/cnt1", 32'(bus_new.counter), 32'd1);
    pulse_write(15'h6000, 8'h00);
    check_val("s4/dis_cnt0", 32'(bus_new.counter), 32'd0);
    check_val("s4/dis_irq", 32'(bus_new.irq), 32'd1);
    pulse(2, 10);
    pulse_write(15'h6001, 8'h00);
    check_val("s4/en_irq_new", 32'(bus_new.irq), 32'd0);
    check_val("s4/en_irq_old", 32'(bus_old.irq), 32'd0);

    cur_tag = "s5_latch0";
    wr(15'h6000, 8'h00); wr(15'h4000, 8'h00); wr(15'h4001, 8'h00); wr(15'h6001, 8'h00);
    for (int i = 0; i < 3; i++) begin
      pulse(2, 10);
      check_val("s5/irq_new", 32'(bus_new.irq), 32'd0);
      check_val("s5/irq_old", 32'(bus_old.irq), 32'd1);
      if (i < 2) begin wr(15'h6000, 8'h00); wr(15'h6001, 8'h00); end
    end

    cur_tag = "s6_reset";
    wr(15'h4000, 8'h07); wr(15'h4001, 8'h00);
    pulse(2, 10);
    check_val("s6/cnt7", 32'(bus_new.counter), 32'd7);
    check_val("s6/irq_low", 32'(bus_new.irq), 32'd0);
    do_reset();
    cur_tag = "s6_after";
    step(1'b1, 15'h4000, 8'h09, 1'b1);
    step(1'b0, 15'h0000, 8'h00, 1'b1);
    idle(4);
    check_val("s6/early_edge", 32'(bus_new.counter), 32'd0);
    pulse(2, 10);
    check_val("s6/cnt9", 32'(bus_new.counter), 32'd9);

    cur_tag = "random";
    a12 = 1'b0;
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        a12 = ~a12;
        run = $urandom_range(1, 6);
      end
      run--;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 5) == 0) begin
        addr = 15'($urandom);
        if ($urandom_range(0, 3) != 0) addr[14] = 1'b1;
        step(1'b1, addr, 8'($urandom), a12);
      end else begin
        step(1'b0, 15'($urandom), 8'($urandom), a12);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
